uart_tx_fifo: RTL and testbench

Parametrised successor to the fixed 8N1 UART transmitter. It has a configurable data width, optional even/odd parity and 1 or 2 stop bits. A synchronous TX FIFO with a valid/ready write handshake lets callers queue multiple words. Frames are sent back-to-back without idle gaps. It sits between the board-level control logic and the uart_txd_out pin, and replaces the single-shot transmitter plus trigger logic in the top level.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_sync_fifo.sv | 73 +++++++
 rtl/uart_tx_fifo.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the parametrised UART transmitter:
//   - parity mode constants (PARITY_NONE / PARITY_EVEN / PARITY_ODD)
//   - transmitter FSM state encoding
//   - even-parity reduction helper
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    localparam int MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Callers zero-extend narrower words, so the unused upper bits do not
    // disturb the reduction.
    function automatic logic even_parity(input logic [MAX_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock FIFO holding words waiting to be serialised.
// Ports:
//   clk, rst        clock and synchronous active-high reset (flushes pointers)
//   i_push, i_data  write request and word; ignored while full or in reset
//   i_pop           read request; ignored while empty
//   o_data          head-of-queue word (valid while !o_empty)
//   o_count         words currently stored (0..DEPTH)
//   o_full/o_empty  status derived from the registered count
// -----------------------------------------------------------------------------
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == CW'(0));
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= AW'(0);
            r_rd_ptr <= AW'(0);
            r_count  <= CW'(0);
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Parametrised UART transmitter with a TX FIFO in front of it. Frames are
// start bit, DATA_BITS data bits LSB first, optional parity, 1 or 2 stop bits,
// sent back-to-back while words remain queued.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   i_valid       write request; accepted when o_ready is high
//   i_data        word to queue (DATA_BITS wide)
//   o_ready       FIFO has room
//   o_tx          registered serial line, idle high
//   o_active      high while a frame is on the line
//   o_done        one-cycle pulse at the end of each frame
//   o_fifo_count  words queued and not yet popped
// -----------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_valid,
    input  logic [DATA_BITS-1:0]          i_data,
    output logic                          o_ready,
    output logic                          o_tx,
    output logic                          o_active,
    output logic                          o_done,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W  = 4;

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_clks
            $error("uart_tx_fifo: CLKS_PER_BIT must be at least 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data
            $error("uart_tx_fifo: DATA_BITS must be in 5..9");
        end
        if (PARITY_MODE < PARITY_NONE || PARITY_MODE > PARITY_ODD) begin : g_bad_parity
            $error("uart_tx_fifo: PARITY_MODE must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_tx_fifo: FIFO_DEPTH must be a power of two, at least 2");
        end
    endgenerate

    logic [DATA_BITS-1:0]          w_fifo_data;
    logic [$clog2(FIFO_DEPTH):0]   w_fifo_count;
    logic                          w_fifo_full;
    logic                          w_fifo_empty;
    logic                          w_push;
    logic                          w_pop;
    logic                          w_bit_end;
    logic                          w_load_parity;
    logic                          w_load;

    tx_state_e            r_state,   w_state_next;
    logic [BAUD_W-1:0]    r_baud,    w_baud_next;
    logic [IDX_W-1:0]     r_bit_idx, w_bit_idx_next;
    logic [DATA_BITS-1:0] r_shift,   w_shift_next;
    logic                 r_parity,  w_parity_next;
    logic                 r_tx,      w_tx_next;
    logic                 r_active,  w_active_next;
    logic                 r_done,    w_done_next;

    // Ready comes from the registered count only, so a pop in the same cycle
    // as a full FIFO cannot make room for a push until the next cycle.
    assign o_ready      = !w_fifo_full;
    assign w_push       = i_valid && o_ready;
    assign o_fifo_count = w_fifo_count;
    assign o_tx         = r_tx;
    assign o_active     = r_active;
    assign o_done       = r_done;

    assign w_bit_end     = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
    // Parity is fixed when the word is loaded because the shift register
    // no longer holds the full word by the time the parity bit goes out.
    assign w_load_parity = even_parity(MAX_DATA_BITS'(w_fifo_data)) ^
                           (PARITY_MODE == PARITY_ODD);

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (i_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        w_state_next   = r_state;
        w_baud_next    = r_baud;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_parity_next  = r_parity;
        w_tx_next      = r_tx;
        w_active_next  = r_active;
        w_done_next    = 1'b0;
        w_load         = 1'b0;
        w_pop          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_tx_next     = 1'b1;
                w_active_next = 1'b0;
                w_baud_next   = BAUD_W'(0);
                w_load        = !w_fifo_empty;
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_next   = ST_DATA;
                    w_baud_next    = BAUD_W'(0);
                    w_bit_idx_next = IDX_W'(0);
                    w_tx_next      = r_shift[0];
                end else begin
                    w_baud_next = r_baud + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_baud_next = BAUD_W'(0);
                    if (r_bit_idx == IDX_W'(DATA_BITS - 1)) begin
                        w_bit_idx_next = IDX_W'(0);
                        if (PARITY_MODE != PARITY_NONE) begin
                            w_state_next = ST_PARITY;
                            w_tx_next    = r_parity;
                        end else begin
                            w_state_next = ST_STOP;
                            w_tx_next    = 1'b1;
                        end
                    end else begin
                        w_bit_idx_next = r_bit_idx + IDX_W'(1);
                        w_shift_next   = {1'b0, r_shift[DATA_BITS-1:1]};
                        w_tx_next      = r_shift[1];
                    end
                end else begin
                    w_baud_next = r_baud + BAUD_W'(1);
                end
            end
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_state_next   = ST_STOP;
                    w_baud_next    = BAUD_W'(0);
                    w_bit_idx_next = IDX_W'(0);
                    w_tx_next      = 1'b1;
                end else begin
                    w_baud_next = r_baud + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    w_baud_next = BAUD_W'(0);
                    if (r_bit_idx == IDX_W'(STOP_BITS - 1)) begin
                        // Frame complete: chain straight into the next start
                        // bit when another word is waiting.
                        w_done_next    = 1'b1;
                        w_bit_idx_next = IDX_W'(0);
                        w_state_next   = ST_IDLE;
                        w_tx_next      = 1'b1;
                        w_active_next  = 1'b0;
                        w_load         = !w_fifo_empty;
                    end else begin
                        w_bit_idx_next = r_bit_idx + IDX_W'(1);
                    end
                end else begin
                    w_baud_next = r_baud + BAUD_W'(1);
                end
            end
            default: begin
                w_state_next  = ST_IDLE;
                w_tx_next     = 1'b1;
                w_active_next = 1'b0;
            end
        endcase

        if (w_load) begin
            w_pop          = 1'b1;
            w_state_next   = ST_START;
            w_baud_next    = BAUD_W'(0);
            w_bit_idx_next = IDX_W'(0);
            w_shift_next   = w_fifo_data;
            w_parity_next  = w_load_parity;
            w_tx_next      = 1'b0;
            w_active_next  = 1'b1;
        end else begin
            w_pop = 1'b0;
        end
    end

    // Sequencer state and registered line outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_baud    <= BAUD_W'(0);
            r_bit_idx <= IDX_W'(0);
            r_shift   <= DATA_BITS'(0);
            r_parity  <= 1'b0;
            r_tx      <= 1'b1;
            r_active  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_baud    <= w_baud_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_parity  <= w_parity_next;
            r_tx      <= w_tx_next;
            r_active  <= w_active_next;
            r_done    <= w_done_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
// Three transmitter instances share one clock and reset:
//   0: 8N1,            CLKS_PER_BIT=4, FIFO_DEPTH=4
//   1: 7 data, even, 2 stop
//   2: 7 data, odd,  2 stop
// A queue-based line model predicts every output each cycle; directed steps
// add fixed expectations for the frame shapes and the corner cases.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int NI    = 3;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       valid_i [NI];
    logic [8:0] din     [NI];
    logic       rdy_o   [NI];
    logic       tx_o    [NI];
    logic       act_o   [NI];
    logic       done_o  [NI];
    logic [2:0] cnt_o   [NI];

    int n_vec = 0;
    int n_err = 0;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0),
                   .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_a (
        .clk(clk), .rst(rst), .i_valid(valid_i[0]), .i_data(din[0][7:0]),
        .o_ready(rdy_o[0]), .o_tx(tx_o[0]), .o_active(act_o[0]),
        .o_done(done_o[0]), .o_fifo_count(cnt_o[0]));

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(1),
                   .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_b (
        .clk(clk), .rst(rst), .i_valid(valid_i[1]), .i_data(din[1][6:0]),
        .o_ready(rdy_o[1]), .o_tx(tx_o[1]), .o_active(act_o[1]),
        .o_done(done_o[1]), .o_fifo_count(cnt_o[1]));

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(2),
                   .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_c (
        .clk(clk), .rst(rst), .i_valid(valid_i[2]), .i_data(din[2][6:0]),
        .o_ready(rdy_o[2]), .o_tx(tx_o[2]), .o_active(act_o[2]),
        .o_done(done_o[2]), .o_fifo_count(cnt_o[2]));

    // ---------------- reference model ----------------
    function automatic int dbits(input int k);
        return (k == 0) ? 8 : 7;
    endfunction
    function automatic int pmode(input int k);
        return k;
    endfunction
    function automatic int sbits(input int k);
        return (k == 0) ? 1 : 2;
    endfunction
    function automatic int flen(input int k);
        return CPB * (1 + dbits(k) + ((pmode(k) != 0) ? 1 : 0) + sbits(k));
    endfunction

    // Bit n of the frame carrying word w: start, data LSB first, parity, stops.
    function automatic logic bit_of(input int k, input int unsigned w, input int n);
        int d;
        logic par;
        d = dbits(k);
        if (n == 0) return 1'b0;
        if (n <= d) return w[n-1];
        if (pmode(k) != 0 && n == d + 1) begin
            par = ($countones(w) % 2) == 1;
            return (pmode(k) == 2) ? !par : par;
        end
        return 1'b1;
    endfunction

    int unsigned mq [NI][$];
    bit          busy   [NI];
    int unsigned cur    [NI];
    int          pos    [NI];
    bit          e_done [NI];
    int          ndone  [NI];

    task automatic model_step(input int k);
        bit acc;
        if (rst) begin
            mq[k].delete();
            busy[k]   = 1'b0;
            pos[k]    = 0;
            e_done[k] = 1'b0;
        end else begin
            acc       = (valid_i[k] === 1'b1) && (mq[k].size() != DEPTH);
            e_done[k] = 1'b0;
            if (busy[k]) begin
                pos[k]++;
                if (pos[k] == flen(k)) begin
                    busy[k]   = 1'b0;
                    e_done[k] = 1'b1;
                end
            end
            if (!busy[k] && mq[k].size() != 0) begin
                cur[k]  = mq[k].pop_front();
                busy[k] = 1'b1;
                pos[k]  = 0;
            end
            if (acc) mq[k].push_back(32'(din[k]) & ((32'd1 << dbits(k)) - 32'd1));
        end
    endtask

    function automatic logic exp_tx(input int k);
        return busy[k] ? bit_of(k, cur[k], pos[k] / CPB) : 1'b1;
    endfunction

    task automatic chk(input string tag, input int k,
                       input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s[%0d]: observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    // One clock: advance the model with the inputs the DUT sees, then compare.
    task automatic cycle();
        @(posedge clk);
        for (int k = 0; k < NI; k++) model_step(k);
        #1;
        for (int k = 0; k < NI; k++) begin
            chk("tx",     k, 32'(tx_o[k]),   32'(exp_tx(k)));
            chk("active", k, 32'(act_o[k]),  32'(busy[k]));
            chk("done",   k, 32'(done_o[k]), 32'(e_done[k]));
            chk("count",  k, 32'(cnt_o[k]),  32'(mq[k].size()));
            chk("ready",  k, 32'(rdy_o[k]),  32'(mq[k].size() != DEPTH));
            if (done_o[k] === 1'b1) ndone[k]++;
        end
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        logic [9:0] seq_a;
        logic       par_b;
        logic       par_c;
        int         done_j [NI];
        int         next_w;
        int         prev_cnt;
        int         n_fp;
        int         act_gaps;
        bit         acc;
        bit         fp_pending;

        for (int k = 0; k < NI; k++) begin
            mq[k].delete();
            busy[k] = 1'b0; pos[k] = 0; e_done[k] = 1'b0; ndone[k] = 0; cur[k] = 0;
            done_j[k] = -1;
        end
        seq_a = 10'd0; par_b = 1'bx; par_c = 1'bx;

        // Reset held with writes pending: nothing may be accepted.
        rst = 1'b1;
        for (int k = 0; k < NI; k++) begin
            valid_i[k] = 1'b1;
            din[k]     = 9'($urandom_range(0, 511));
        end
        repeat (3) cycle();
        for (int k = 0; k < NI; k++) begin
            chk("rst_tx",    k, 32'(tx_o[k]),  32'd1);
            chk("rst_ready", k, 32'(rdy_o[k]), 32'd1);
            chk("rst_count", k, 32'(cnt_o[k]), 32'd0);
            chk("rst_act",   k, 32'(act_o[k]), 32'd0);
        end
        rst = 1'b0;
        for (int k = 0; k < NI; k++) valid_i[k] = 1'b0;
        repeat (2) cycle();
        for (int k = 0; k < NI; k++) chk("rst_no_tx", k, 32'(tx_o[k]), 32'd1);

        // Single frames: 0xA5 on 8N1, 0x55 on 7E2 and 7O2.
        din[0] = 9'h0A5; din[1] = 9'h055; din[2] = 9'h055;
        for (int k = 0; k < NI; k++) begin valid_i[k] = 1'b1; ndone[k] = 0; end
        cycle();
        for (int k = 0; k < NI; k++) valid_i[k] = 1'b0;
        cycle();
        for (int k = 0; k < NI; k++) chk("fall_latency", k, 32'(tx_o[k]), 32'd0);
        for (int j = 1; j <= 48; j++) begin
            cycle();
            if (j % 4 == 2 && j < 40) seq_a[j / 4] = tx_o[0];
            if (j == 34) begin par_b = tx_o[1]; par_c = tx_o[2]; end
            for (int k = 0; k < NI; k++) if (done_o[k] === 1'b1) done_j[k] = j;
        end
        chk("seq_a5",     0, 32'(seq_a),  32'h34A);   // 10'b1101001010, first bit in bit 0
        chk("done_at",    0, done_j[0],   32'd40);
        chk("done_at",    1, done_j[1],   32'd44);
        chk("done_at",    2, done_j[2],   32'd44);
        chk("parity_even",1, 32'(par_b),  32'd0);
        chk("parity_odd", 2, 32'(par_c),  32'd1);
        for (int k = 0; k < NI; k++) begin
            chk("one_done",  k, ndone[k],      32'd1);
            chk("idle_act",  k, 32'(act_o[k]), 32'd0);
        end

        // Back-to-back burst of 0x01..0x08 into the 4-deep FIFO.
        ndone[0] = 0; next_w = 1; n_fp = 0; act_gaps = 0; fp_pending = 1'b0;
        prev_cnt = 0;
        valid_i[0] = 1'b1; din[0] = 9'd1;
        for (int c = 0; c < 400; c++) begin
            acc = (valid_i[0] === 1'b1) && (mq[0].size() != DEPTH);
            cycle();
            if (prev_cnt == 4 && done_o[0] === 1'b1) begin
                chk("full_pop_cnt", 0, 32'(cnt_o[0]), 32'd3);
                chk("full_pop_rdy", 0, 32'(rdy_o[0]), 32'd1);
                fp_pending = (valid_i[0] === 1'b1);
                n_fp++;
            end else if (fp_pending) begin
                chk("full_refill", 0, 32'(cnt_o[0]), 32'd4);
                fp_pending = 1'b0;
            end
            prev_cnt = int'(cnt_o[0]);
            if (c > 0 && ndone[0] < 8 && act_o[0] !== 1'b1) act_gaps++;
            if (acc) begin
                if (next_w == 8) valid_i[0] = 1'b0;
                else begin next_w++; din[0] = 9'(next_w); end
            end
        end
        chk("burst_done",  0, ndone[0], 32'd8);
        chk("full_pops",   0, n_fp,     32'd4);
        chk("active_gaps", 0, act_gaps, 32'd0);

        // Reset in the middle of DATA bit 3 with two words still queued.
        din[0] = 9'h03C; valid_i[0] = 1'b1;
        cycle();
        din[0] = 9'h0C3;
        cycle();
        din[0] = 9'h099;
        cycle();
        valid_i[0] = 1'b0;
        chk("mid_queued", 0, 32'(cnt_o[0]), 32'd2);
        repeat (16) cycle();
        rst = 1'b1; ndone[0] = 0;
        cycle();
        rst = 1'b0;
        chk("mid_rst_tx",   0, 32'(tx_o[0]),   32'd1);
        chk("mid_rst_cnt",  0, 32'(cnt_o[0]),  32'd0);
        chk("mid_rst_done", 0, 32'(done_o[0]), 32'd0);
        repeat (5) cycle();
        chk("mid_no_done", 0, ndone[0], 32'd0);
        din[0] = 9'h05A; valid_i[0] = 1'b1;
        cycle();
        valid_i[0] = 1'b0;
        cycle();
        chk("post_rst_fall", 0, 32'(tx_o[0]), 32'd0);
        repeat (45) cycle();
        chk("post_rst_done", 0, ndone[0], 32'd1);

        // Random traffic with occasional resets.
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < NI; k++) begin
                valid_i[k] = ($urandom_range(0, 3) == 0);
                din[k]     = 9'($urandom_range(0, 511));
            end
            rst = ($urandom_range(0, 399) == 0);
            cycle();
        end
        rst = 1'b0;
        for (int k = 0; k < NI; k++) valid_i[k] = 1'b0;
        repeat (300) cycle();
        for (int k = 0; k < NI; k++) begin
            chk("drain_cnt", k, 32'(cnt_o[k]), 32'd0);
            chk("drain_act", k, 32'(act_o[k]), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
